// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Sequencing controller for the PC and the IF/ID pipeline register. It
//   detects load-use hazards, taken branches, jumps and data-memory wait. From
//   these it drives the PC / IF/ID enables, the IF/ID flush and the ID/EX
//   bubble insert. It also keeps saturating stall/flush counters and a sticky
//   memory-wait watchdog.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   id_rs, id_rt        source fields of the instruction in ID
//   id_uses_rt          ID instruction reads rt as a source
//   ex_mem_read, ex_rt  EX instruction is a load, and its destination register
//   ex_branch_taken     branch resolved taken in EX
//   id_jump             ID instruction is a jump
//   mem_wait            data memory not ready; the whole pipe freezes
//   pc_write            PC load enable
//   if_id_write         IF/ID load enable
//   if_id_flush         IF/ID loads a NOP
//   id_ex_bubble        ID/EX loads zero control
//   ctrl_state          FSM state (0 RUN, 1 FLUSH, 2 WAIT), for observation
//   wait_timeout        sticky: mem_wait lasted MAX_WAIT consecutive cycles
//   stall_count         cycles with pc_write=0, saturating
//   flush_count         branch/jump flush events, saturating
//
// The control outputs are combinational from the registered state and the
// current inputs, and they are forced low while reset is asserted.
module pipeline_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MAX_WAIT     = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             id_jump,
  input  logic             mem_wait,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       ctrl_state,
  output logic             wait_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_BAD   = 2'd3
  } state_e;

  localparam int unsigned FL_W = $clog2(FLUSH_CYCLES + 1);
  localparam int unsigned WT_W = $clog2(MAX_WAIT + 1);

  localparam logic [FL_W-1:0]  FL_INIT  = FL_W'(FLUSH_CYCLES - 1);
  localparam logic [FL_W-1:0]  FL_ONE   = FL_W'(1);
  localparam logic [WT_W-1:0]  WT_MAX   = WT_W'(MAX_WAIT);
  localparam logic [WT_W-1:0]  WT_ONE   = WT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [FL_W-1:0]  fl_cnt_q, fl_cnt_d;
  logic [WT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic hz;
  logic pc_w, ifid_w, ifid_fl, bub;
  logic flush_evt;

  always_comb begin
    // A load whose destination feeds the ID instruction; r0 never hazards.
    hz = ex_mem_read && (ex_rt != 5'd0) &&
         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    pc_w       = 1'b1;
    ifid_w     = 1'b1;
    ifid_fl    = 1'b0;
    bub        = 1'b0;
    flush_evt  = 1'b0;
    state_d    = ST_RUN;
    fl_cnt_d   = fl_cnt_q;
    wait_cnt_d = '0;
    timeout_d  = timeout_q;

    case (state_q)
      ST_FLUSH: begin
        if (mem_wait) begin
          // Freeze: the remaining flush cycles are kept for after the wait.
          pc_w    = 1'b0;
          ifid_w  = 1'b0;
          state_d = ST_FLUSH;
        end else begin
          ifid_fl  = 1'b1;
          bub      = 1'b1;
          fl_cnt_d = fl_cnt_q - FL_ONE;
          state_d  = (fl_cnt_q == FL_ONE) ? ST_RUN : ST_FLUSH;
        end
      end
      default: begin
        // RUN, WAIT and the unused encoding share one priority list.
        if (mem_wait) begin
          pc_w    = 1'b0;
          ifid_w  = 1'b0;
          state_d = ST_WAIT;
          if (state_q == ST_WAIT) begin
            wait_cnt_d = (wait_cnt_q >= WT_MAX) ? WT_MAX : (wait_cnt_q + WT_ONE);
          end else begin
            wait_cnt_d = WT_ONE;
          end
          // Sets once the run of wait cycles (this one included) reaches MAX_WAIT.
          if (wait_cnt_d == WT_MAX) timeout_d = 1'b1;
        end else if (ex_branch_taken) begin
          ifid_fl   = 1'b1;
          bub       = 1'b1;
          flush_evt = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d  = ST_FLUSH;
            fl_cnt_d = FL_INIT;
          end
        end else if (hz) begin
          pc_w   = 1'b0;
          ifid_w = 1'b0;
          bub    = 1'b1;
        end else if (id_jump) begin
          ifid_fl   = 1'b1;
          flush_evt = 1'b1;
        end
        if (state_q == ST_BAD) state_d = ST_RUN;
      end
    endcase

    stall_d = (!pc_w && (stall_q != '1)) ? (stall_q + CNT_ONE) : stall_q;
    flush_d = (flush_evt && (flush_q != '1)) ? (flush_q + CNT_ONE) : flush_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      fl_cnt_q   <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      fl_cnt_q   <= fl_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  assign pc_write     = reset & pc_w;
  assign if_id_write  = reset & ifid_w;
  assign if_id_flush  = reset & ifid_fl;
  assign id_ex_bubble = reset & bub;
  assign ctrl_state   = state_q;
  assign wait_timeout = timeout_q;
  assign stall_count  = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int FLC = 3;
  localparam int MW  = 16;
  localparam int CW  = 16;
  localparam int CWS = 4;

  // ---------------- clock / reset / inputs ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, ex_branch_taken, id_jump, mem_wait;

  logic          pc_write, if_id_write, if_id_flush, id_ex_bubble, wait_timeout;
  logic [1:0]    ctrl_state;
  logic [CW-1:0] stall_count, flush_count;

  logic           s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble, s_wait_timeout;
  logic [1:0]     s_ctrl_state;
  logic [CWS-1:0] s_stall_count, s_flush_count;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(FLC), .MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .id_jump(id_jump), .mem_wait(mem_wait), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .ctrl_state(ctrl_state),
    .wait_timeout(wait_timeout), .stall_count(stall_count), .flush_count(flush_count)
  );

  // Narrow-counter copy so saturation is reached within a short run.
  pipeline_hazard_ctrl #(.FLUSH_CYCLES(FLC), .MAX_WAIT(MW), .CNT_W(CWS)) dut_sat (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .id_jump(id_jump), .mem_wait(mem_wait), .pc_write(s_pc_write), .if_id_write(s_if_id_write),
    .if_id_flush(s_if_id_flush), .id_ex_bubble(s_id_ex_bubble), .ctrl_state(s_ctrl_state),
    .wait_timeout(s_wait_timeout), .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  // ---------------- bookkeeping ----------------
  int n_chk  = 0;
  int n_fail = 0;
  logic [1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  int m_state, m_fl_left, m_wait_run, m_stall, m_flush;
  bit m_to;

  always @(negedge clk) begin : cmp
    logic hz_m, e_pc, e_ifw, e_fl, e_bub;
    int   n_st;
    if (!reset) begin
      chk("rst_ctrl", {28'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble}, 32'd0);
      chk("rst_state", ctrl_state, 0);
      chk("rst_cnt", {stall_count, flush_count}, 0);
      chk("rst_to", wait_timeout, 0);
      chk("rst_s_all", {s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble,
                        s_ctrl_state, s_wait_timeout, s_stall_count, s_flush_count}, 0);
      m_state = 0; m_fl_left = 0; m_wait_run = 0; m_stall = 0; m_flush = 0; m_to = 0;
    end else begin
      chk("m_state", ctrl_state, m_state);
      chk("m_stall", stall_count, sat(m_stall, CW));
      chk("m_flush", flush_count, sat(m_flush, CW));
      chk("m_to", wait_timeout, m_to);
      chk("m_s_state", s_ctrl_state, m_state);
      chk("m_s_stall", s_stall_count, sat(m_stall, CWS));
      chk("m_s_flush", s_flush_count, sat(m_flush, CWS));
      chk("m_s_to", s_wait_timeout, m_to);

      hz_m = ex_mem_read && (ex_rt != 0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
      e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0; n_st = 0;
      if (m_state == 1) begin
        m_wait_run = 0;
        if (mem_wait) begin
          e_pc = 0; e_ifw = 0; n_st = 1;
        end else begin
          e_fl = 1; e_bub = 1;
          m_fl_left--;
          n_st = (m_fl_left == 0) ? 0 : 1;
        end
      end else if (mem_wait) begin
        e_pc = 0; e_ifw = 0; n_st = 2;
        m_wait_run++;
        if (m_wait_run >= MW) m_to = 1;
      end else begin
        m_wait_run = 0;
        if (ex_branch_taken) begin
          e_fl = 1; e_bub = 1; m_flush++;
          if (FLC > 1) begin n_st = 1; m_fl_left = FLC - 1; end
        end else if (hz_m) begin
          e_pc = 0; e_ifw = 0; e_bub = 1;
        end else if (id_jump) begin
          e_fl = 1; m_flush++;
        end
      end
      chk("m_ctrl", {pc_write, if_id_write, if_id_flush, id_ex_bubble}, {e_pc, e_ifw, e_fl, e_bub});
      chk("m_s_ctrl", {s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble},
          {e_pc, e_ifw, e_fl, e_bub});
      if (!e_pc) m_stall++;
      m_state = n_st;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                        input logic mr, input logic [4:0] xrt, input logic br,
                        input logic jp, input logic mw);
    id_rs = rs; id_rt = rt; id_uses_rt = ur; ex_mem_read = mr; ex_rt = xrt;
    ex_branch_taken = br; id_jump = jp; mem_wait = mw;
  endtask

  task automatic idle();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of a vector, checked only by the model.
  task automatic run_vec(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                         input logic mr, input logic [4:0] xrt, input logic br,
                         input logic jp, input logic mw);
    set_in(rs, rt, ur, mr, xrt, br, jp, mw);
    tick();
  endtask

  // ---------------- directed stimulus ----------------
  int n_fl;

  initial begin
    reset = 1'b0;
    idle();
    #2;
    chk("rst_pc", pc_write, 0);
    chk("rst_ifw", if_id_write, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Idle defaults
    idle(); #1;
    chk("idle_pc", pc_write, 1);
    chk("idle_bub", id_ex_bubble, 0);
    chk("idle_state", ctrl_state, 0);
    tick();

    // Load-use on rs
    set_in(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0); #1;
    chk("lu_pc", pc_write, 0);
    chk("lu_ifw", if_id_write, 0);
    chk("lu_bub", id_ex_bubble, 1);
    chk("lu_fl", if_id_flush, 0);
    tick();
    idle(); #1;
    chk("lu_after_pc", pc_write, 1);
    chk("lu_after_bub", id_ex_bubble, 0);
    chk("lu_stall", stall_count, 1);
    tick();

    // r0 never hazards; rt only counts when it is read
    set_in(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0); #1;
    chk("r0_pc", pc_write, 1);
    tick();
    set_in(5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0); #1;
    chk("rt_unused_pc", pc_write, 1);
    tick();
    set_in(5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0); #1;
    chk("rt_used_pc", pc_write, 0);
    chk("rt_used_bub", id_ex_bubble, 1);
    tick();
    idle(); #1;
    chk("stall_2", stall_count, 2);
    tick();

    // Taken branch: three flush cycles, states 0,1,1,0; inputs ignored in FLUSH
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd1); exp_q.push_back(2'd0);
    n_fl = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      else if (i < 3) set_in(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0);
      else idle();
      #1;
      chk("br_state", ctrl_state, exp_q.pop_front());
      if (if_id_flush) n_fl++;
      if (i < 3) chk("br_pc", pc_write, 1);
      tick();
    end
    chk("br_cycles", n_fl, 3);
    chk("br_count", flush_count, 1);
    chk("br_stall", stall_count, 2);

    // Branch and hazard together: branch wins
    set_in(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0); #1;
    chk("brhz_pc", pc_write, 1);
    chk("brhz_fl", if_id_flush, 1);
    tick();
    idle(); tick(); tick(); #1;
    chk("brhz_stall", stall_count, 2);
    chk("brhz_count", flush_count, 2);
    chk("brhz_state", ctrl_state, 0);

    // Jump: one-cycle flush, no bubble
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); #1;
    chk("jmp_fl", if_id_flush, 1);
    chk("jmp_bub", id_ex_bubble, 0);
    chk("jmp_pc", pc_write, 1);
    tick();
    idle(); #1;
    chk("jmp_count", flush_count, 3);
    chk("jmp_state", ctrl_state, 0);
    tick();

    // mem_wait for 20 cycles
    for (int i = 0; i < 20; i++) begin
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1); #1;
      chk("mw_frz", {pc_write, if_id_write, if_id_flush, id_ex_bubble}, 0);
      tick();
      chk("mw_to", wait_timeout, (i >= 15) ? 1 : 0);
    end
    idle(); #1;
    chk("mw_end_state", ctrl_state, 2);
    chk("mw_end_pc", pc_write, 1);
    chk("mw_stall", stall_count, 22);
    tick();
    #1;
    chk("mw_run", ctrl_state, 0);
    chk("mw_sticky", wait_timeout, 1);

    // mem_wait inside FLUSH stretches it but keeps exactly three flush cycles
    n_fl = 0;
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0); #1;
    if (if_id_flush) n_fl++;
    tick();
    idle(); #1;
    chk("flw_state1", ctrl_state, 1);
    if (if_id_flush) n_fl++;
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1); #1;
      chk("flw_hold", ctrl_state, 1);
      chk("flw_frz", {pc_write, if_id_write, if_id_flush, id_ex_bubble}, 0);
      if (if_id_flush) n_fl++;
      tick();
    end
    idle(); #1;
    chk("flw_resume", if_id_flush, 1);
    if (if_id_flush) n_fl++;
    tick();
    idle(); #1;
    chk("flw_done", ctrl_state, 0);
    if (if_id_flush) n_fl++;
    chk("flw_cycles", n_fl, 3);
    chk("flw_stall", stall_count, 25);
    chk("flw_count", flush_count, 4);
    tick();

    // Reset in the middle of WAIT takes effect without a clock edge
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick(); tick(); tick();
    chk("pre_rst_stall", stall_count, 28);
    chk("pre_rst_state", ctrl_state, 2);
    #2 reset = 1'b0;
    #1;
    chk("ar_state", ctrl_state, 0);
    chk("ar_cnt", {stall_count, flush_count}, 0);
    chk("ar_to", wait_timeout, 0);
    chk("ar_ctrl", {pc_write, if_id_write, if_id_flush, id_ex_bubble}, 0);
    idle();
    @(posedge clk);
    #1 reset = 1'b1;

    // Mixed vectors, model-checked: WAIT exit into branch / hazard / jump
    run_vec(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    run_vec(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    run_vec(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    run_vec(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    run_vec(5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    run_vec(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    run_vec(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    run_vec(5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    run_vec(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0);
    run_vec(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    run_vec(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    run_vec(5'd2, 5'd3, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
    run_vec(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
